cmd_latch: RTL and testbench

- Parametrised command latch/priority encoder for the clock's push-button command path: N_CMD asynchronous request lines in, one prioritised command code out to the time counter.
- Each request is synchronised and rising-edge detected, then held pending until the counter acknowledges it.
- Serves multiple pending commands in fixed priority and flags lost presses.
- Sits between the button inputs and the counter/control logic.

---
 rtl/clock_pkg.sv | 18 +
 rtl/cmd_latch_if.sv | 35 +++
 rtl/debounce_cell.sv | 34 +++
 rtl/cmd_latch.sv | 90 +++++++++
 tb/tb_cmd_latch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock's push-button command path: channel indices,
// matching command codes and the default channel count.
package clock_pkg;

  localparam int unsigned N_CMD_DEF = 3;

  localparam int unsigned CMD_MADD = 0;
  localparam int unsigned CMD_STO0 = 1;
  localparam int unsigned CMD_RES  = 2;

  typedef enum logic [1:0] {
    CodeIdle = 2'd0,
    CodeMadd = 2'(CMD_MADD + 1),
    CodeSto0 = 2'(CMD_STO0 + 1),
    CodeRes  = 2'(CMD_RES + 1)
  } cmd_code_e;

endpackage

// File: rtl/cmd_latch_if.sv
// Command request/ack bundle between the button front-end and the time counter.
interface cmd_latch_if
  import clock_pkg::*;
#(
  parameter int unsigned N_CMD = N_CMD_DEF
) ();

  localparam int unsigned CODE_W = $clog2(N_CMD + 1);

  logic [N_CMD-1:0]  cmd_req;
  logic              cmd_ack;
  logic              cmd_valid;
  logic [CODE_W-1:0] cmd_code;
  logic [N_CMD-1:0]  pending;
  logic [N_CMD-1:0]  overrun;

  modport master (
    output cmd_req,
    output cmd_ack,
    input  cmd_valid,
    input  cmd_code,
    input  pending,
    input  overrun
  );

  modport slave (
    input  cmd_req,
    input  cmd_ack,
    output cmd_valid,
    output cmd_code,
    output pending,
    output overrun
  );

endinterface

// File: rtl/debounce_cell.sv
// Single-channel level filter: the output follows the input only after the input
// has held a new value for DB_CYCLES consecutive clocks.
module debounce_cell #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (i_level == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CntLast) begin
      r_level <= i_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/cmd_latch.sv
// Command latch / priority encoder for the push-button path.
// Define CMD_LATCH_DEBOUNCE_EN to insert a debounce_cell per channel before edge detect.
module cmd_latch
  import clock_pkg::*;
#(
  parameter int unsigned N_CMD     = N_CMD_DEF,
  parameter int unsigned DB_CYCLES = 16
) (
  input logic        clk,
  input logic        rst,
  cmd_latch_if.slave io_bus
);

  localparam int unsigned CODE_W = $clog2(N_CMD + 1);

  if (N_CMD < 2 || N_CMD > 15) begin : g_bad_n_cmd
    $error("cmd_latch: N_CMD must be in 2..15");
  end
  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("cmd_latch: DB_CYCLES must be at least 1");
  end

  logic [N_CMD-1:0]  r_sync1, r_sync2, r_hist, r_pending, r_overrun;
  logic [N_CMD-1:0]  w_level, w_edge, w_grant, w_ack_clr;
  logic [N_CMD-1:0]  w_pending_d, w_overrun_d;
  logic [CODE_W-1:0] w_code;
  logic              w_valid;

`ifdef CMD_LATCH_DEBOUNCE_EN
  for (genvar gi = 0; gi < N_CMD; gi++) begin : g_db
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_level(r_sync2[gi]),
      .o_level(w_level[gi])
    );
  end
`else
  assign w_level = r_sync2;
`endif

  assign w_edge  = w_level & ~r_hist;
  // Isolate the lowest set bit: the channel currently presented.
  assign w_grant = r_pending & (~r_pending + N_CMD'(1));
  assign w_valid = |r_pending;

  always_comb begin
    w_code = '0;
    for (int i = N_CMD - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_code = CODE_W'(i + 1);
      end
    end
  end

  always_comb begin
    w_ack_clr = '0;
    if (io_bus.cmd_ack && w_valid) begin
      w_ack_clr = w_grant;
    end
  end

  // A new edge on a channel being acked in this cycle re-arms it without overrun.
  assign w_pending_d = w_edge | (r_pending & ~w_ack_clr);
  assign w_overrun_d = r_overrun | (w_edge & r_pending & ~w_ack_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_hist    <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_sync1   <= io_bus.cmd_req;
      r_sync2   <= r_sync1;
      r_hist    <= w_level;
      r_pending <= w_pending_d;
      r_overrun <= w_overrun_d;
    end
  end

  assign io_bus.cmd_valid = w_valid;
  assign io_bus.cmd_code  = w_code;
  assign io_bus.pending   = r_pending;
  assign io_bus.overrun   = r_overrun;

endmodule

// File: tb/tb_cmd_latch.sv
// Self-checking bench for cmd_latch (default build, no debounce filter).
module tb_cmd_latch;

  localparam int unsigned NC = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model: per-edge history of sampled request levels, pending/overrun sets.
  logic [NC-1:0] m_hist[$];
  logic [NC-1:0] m_pend;
  logic [NC-1:0] m_ovr;
  logic [NC-1:0] cur_req;

  cmd_latch_if #(.N_CMD(NC)) u_if ();

  cmd_latch #(
    .N_CMD    (NC),
    .DB_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(u_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_code();
    for (int i = 0; i < NC; i++) begin
      if (m_pend[i]) return 2'(i + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic [8:0] exp_vec();
    return {(m_pend != '0), exp_code(), m_pend, m_ovr};
  endfunction

  function automatic logic [8:0] got_vec();
    return {u_if.cmd_valid, u_if.cmd_code, u_if.pending, u_if.overrun};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle outputs.
  task automatic step(input logic [NC-1:0] req, input logic ack, input logic rst_v);
    logic [NC-1:0] ev;
    int            acked;
    int            n;
    @(negedge clk);
    u_if.cmd_req = req;
    u_if.cmd_ack = ack;
    rst          = rst_v;
    cur_req      = req;
    @(posedge clk);
    n = m_hist.size();
    if (rst_v) begin
      m_pend      = '0;
      m_ovr       = '0;
      m_hist[n-1] = '0;
      m_hist[n-2] = '0;
      m_hist.push_back('0);
    end else begin
      // A press is a low-to-high step in the sampled level, seen two edges later.
      ev    = m_hist[n-2] & ~m_hist[n-3];
      acked = (ack && m_pend != '0) ? int'(exp_code()) - 1 : -1;
      for (int i = 0; i < NC; i++) begin
        if (ev[i]) begin
          if (m_pend[i] && acked != i) m_ovr[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (acked == i) begin
          m_pend[i] = 1'b0;
        end
      end
      m_hist.push_back(req);
    end
    if (m_hist.size() > 8) void'(m_hist.pop_front());
    #1;
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(3'b111, 1'b0, 1'b1);
      checks++;
      if (got_vec() !== 9'd0) begin
        errors++;
        $display("FAIL reset_hold: got %b, want %b", got_vec(), 9'd0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 1'b0, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
    end
    checks++;
    if (u_if.cmd_code !== 2'd1 || u_if.pending !== 3'b111) begin
      errors++;
      $display("FAIL reset_latency: got code=%0d pend=%b, want code=1 pend=111",
               u_if.cmd_code, u_if.pending);
    end
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 1'b1, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_drain k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_press();
    logic [3:0] tbl[10];
    tbl = '{4'b000_0, 4'b000_0, 4'b010_0, 4'b010_0, 4'b010_0,
            4'b010_1, 4'b010_0, 4'b010_0, 4'b010_0, 4'b010_0};
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k][3:1], tbl[k][0], 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_press k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
      if (k == 4) begin
        checks++;
        if (u_if.pending !== 3'b010 || u_if.cmd_code !== 2'd2) begin
          errors++;
          $display("FAIL single_latency: got pend=%b code=%0d, want pend=010 code=2",
                   u_if.pending, u_if.cmd_code);
        end
      end
    end
    checks++;
    if (u_if.cmd_valid !== 1'b0 || u_if.cmd_code !== 2'd0) begin
      errors++;
      $display("FAIL single_held: got valid=%b code=%0d, want valid=0 code=0",
               u_if.cmd_valid, u_if.cmd_code);
    end
  endtask

  task automatic test_priority();
    logic [3:0] tbl[10];
    tbl = '{4'b100_0, 4'b100_0, 4'b101_0, 4'b101_0, 4'b101_0,
            4'b101_0, 4'b101_1, 4'b101_0, 4'b101_1, 4'b101_0};
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k][3:1], tbl[k][0], 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL priority k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ack_collision();
    logic [3:0] tbl[7];
    tbl = '{4'b010_0, 4'b000_0, 4'b000_0, 4'b010_0, 4'b000_0, 4'b000_1, 4'b000_1};
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k][3:1], tbl[k][0], 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ack_collision k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
      if (k == 5) begin
        checks++;
        if (u_if.pending[1] !== 1'b1 || u_if.overrun[1] !== 1'b0) begin
          errors++;
          $display("FAIL collision_keep: got pend1=%b ovr1=%b, want pend1=1 ovr1=0",
                   u_if.pending[1], u_if.overrun[1]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [3:0] tbl[8];
    tbl = '{4'b001_0, 4'b000_0, 4'b000_0, 4'b001_0, 4'b000_0, 4'b000_0, 4'b000_1, 4'b000_0};
    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k][3:1], tbl[k][0], 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overrun k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
    end
    checks++;
    if (u_if.overrun !== 3'b001 || u_if.pending !== 3'b000) begin
      errors++;
      $display("FAIL overrun_sticky: got ovr=%b pend=%b, want ovr=001 pend=000",
               u_if.overrun, u_if.pending);
    end
    step('0, 1'b0, 1'b1);
    checks++;
    if (u_if.overrun !== 3'b000) begin
      errors++;
      $display("FAIL overrun_clear: got ovr=%b, want 000", u_if.overrun);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] req;
    logic          ack;
    logic          r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req = cur_req;
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
      end
      ack = ($urandom_range(2) == 0);
      r   = ($urandom_range(99) == 0);
      step(req, ack, r);
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random k=%0d: got %b, want %b", k, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    u_if.cmd_req = '0;
    u_if.cmd_ack = 1'b0;
    cur_req      = '0;
    m_pend       = '0;
    m_ovr        = '0;
    m_hist       = '{3'b000, 3'b000, 3'b000};
    test_reset();
    test_single_press();
    test_priority();
    test_ack_collision();
    test_overrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
